fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit.sv | 102 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding with load-use stall control and stall-timeout flag.
// Defining HAZARD_PERF_EN adds the stall_cycles counter port.
module fwd_hazard_unit #(
  parameter int XLEN = 32,
  parameter int AW = 5,
  parameter int MAX_WAIT = 8,
  parameter int PERF_W = 32,
  localparam int CW = $clog2(MAX_WAIT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1_sel,
  input  logic [AW-1:0]   id_rs2_sel,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [XLEN-1:0] rgf_rs1_val,
  input  logic [XLEN-1:0] rgf_rs2_val,
  input  logic            ex_valid,
  input  logic            ex_we,
  input  logic            ex_is_load,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_val,
  input  logic            mem_valid,
  input  logic            mem_we,
  input  logic            mem_is_load,
  input  logic            mem_load_done,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_val,
  input  logic            wb_valid,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_val,
  output logic            stall,
  output logic [XLEN-1:0] fwd_rs1_val,
  output logic [XLEN-1:0] fwd_rs2_val,
  output logic [1:0]      fwd_rs1_src,
  output logic [1:0]      fwd_rs2_src,
  output logic [CW-1:0]   wait_cnt,
  output logic            timeout_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles
`endif
);
  typedef enum logic {RUN, WAIT} state_t;
  state_t state_q, state_d;
  logic [1:0][AW-1:0] sel;
  logic [1:0] use_s, hz;
  logic [1:0][XLEN-1:0] rgf, val;
  logic [1:0][1:0] src;
  logic [CW-1:0] cnt_d;
  assign sel = {id_rs2_sel, id_rs1_sel};
  assign use_s = {id_use_rs2, id_use_rs1};
  assign rgf = {rgf_rs2_val, rgf_rs1_val};
  for (genvar s = 0; s < 2; s++) begin : g_src
    logic ex_m, mem_m, wb_m, mem_blk;
    // The first matching stage alone decides; a blocked match never falls through.
    always_comb begin
      ex_m = ex_valid & ex_we & (ex_rd == sel[s]) & (sel[s] != '0) & use_s[s];
      mem_m = mem_valid & mem_we & (mem_rd == sel[s]) & (sel[s] != '0) & use_s[s];
      wb_m = wb_valid & wb_we & (wb_rd == sel[s]) & (sel[s] != '0) & use_s[s];
      mem_blk = mem_is_load & ~mem_load_done;
      hz[s] = ex_m ? ex_is_load : mem_m & mem_blk;
      src[s] = ex_m ? (ex_is_load ? 2'd0 : 2'd1) :
               mem_m ? (mem_blk ? 2'd0 : 2'd2) :
               wb_m ? 2'd3 : 2'd0;
      val[s] = src[s] == 2'd1 ? ex_val :
               src[s] == 2'd2 ? mem_val :
               src[s] == 2'd3 ? wb_val : rgf[s];
    end
  end
  assign fwd_rs1_val = val[0];
  assign fwd_rs2_val = val[1];
  assign fwd_rs1_src = src[0];
  assign fwd_rs2_src = src[1];
  assign stall = id_valid & ~flush & (hz[0] | hz[1]);
  always_comb begin
    state_d = stall ? WAIT : RUN;
    cnt_d = !stall ? '0 :
            state_q == RUN ? CW'(1) :
            wait_cnt == CW'(MAX_WAIT) ? wait_cnt : wait_cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_cnt <= cnt_d;
      if (stall && wait_cnt == CW'(MAX_WAIT)) timeout_err <= 1'b1;
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles <= '0;
    else stall_cycles <= stall_cycles + PERF_W'(stall);
  end
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed scenarios plus a per-cycle model comparison.
module tb_fwd_hazard_unit;
  localparam int XLEN = 32, AW = 5, MAXW = 8, PW = 32, CW = 4;
  logic clk = 0, rst_n = 0, flush = 0, id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0;
  logic [AW-1:0] id_rs1_sel = 0, id_rs2_sel = 0, ex_rd = 0, mem_rd = 0, wb_rd = 0;
  logic [XLEN-1:0] rgf_rs1_val = 0, rgf_rs2_val = 0, ex_val = 0, mem_val = 0, wb_val = 0;
  logic ex_valid = 0, ex_we = 0, ex_is_load = 0;
  logic mem_valid = 0, mem_we = 0, mem_is_load = 0, mem_load_done = 0;
  logic wb_valid = 0, wb_we = 0;
  logic stall, timeout_err;
  logic [XLEN-1:0] fwd_rs1_val, fwd_rs2_val;
  logic [1:0] fwd_rs1_src, fwd_rs2_src;
  logic [CW-1:0] wait_cnt;
`ifdef HAZARD_PERF_EN
  logic [PW-1:0] stall_cycles;
  int m_perf = 0;
`endif
  int compared = 0, mismatched = 0;
  int run = 0;
  bit m_to = 0;

  fwd_hazard_unit #(.XLEN(XLEN), .AW(AW), .MAX_WAIT(MAXW), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
    .id_rs1_sel(id_rs1_sel), .id_rs2_sel(id_rs2_sel),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .rgf_rs1_val(rgf_rs1_val), .rgf_rs2_val(rgf_rs2_val),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_val(ex_val),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_is_load(mem_is_load),
    .mem_load_done(mem_load_done), .mem_rd(mem_rd), .mem_val(mem_val),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_val(wb_val),
    .stall(stall), .fwd_rs1_val(fwd_rs1_val), .fwd_rs2_val(fwd_rs2_val),
    .fwd_rs1_src(fwd_rs1_src), .fwd_rs2_src(fwd_rs2_src),
    .wait_cnt(wait_cnt), .timeout_err(timeout_err)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Scan stages youngest-first; a stage whose value is not ready yet blocks the source.
  function automatic void resolve(input logic [AW-1:0] sel, input logic use_s, input logic [XLEN-1:0] rgf,
                                  output logic hz, output logic [1:0] s, output logic [XLEN-1:0] v);
    logic [AW-1:0] rd [3];
    logic [XLEN-1:0] vals [3];
    logic live [3], blocked [3];
    rd[0] = ex_rd; rd[1] = mem_rd; rd[2] = wb_rd;
    vals[0] = ex_val; vals[1] = mem_val; vals[2] = wb_val;
    live[0] = ex_valid && ex_we; live[1] = mem_valid && mem_we; live[2] = wb_valid && wb_we;
    blocked[0] = ex_is_load; blocked[1] = mem_is_load && !mem_load_done; blocked[2] = 0;
    hz = 0; s = 0; v = rgf;
    if (!use_s || sel == 0) return;
    for (int k = 0; k < 3; k++)
      if (live[k] && rd[k] == sel) begin
        if (blocked[k]) hz = 1;
        else begin s = 2'(k + 1); v = vals[k]; end
        return;
      end
  endfunction

  function automatic logic model_stall();
    logic h1, h2;
    logic [1:0] s;
    logic [XLEN-1:0] v;
    resolve(id_rs1_sel, id_use_rs1, rgf_rs1_val, h1, s, v);
    resolve(id_rs2_sel, id_use_rs2, rgf_rs2_val, h2, s, v);
    return id_valid && !flush && (h1 || h2);
  endfunction

  // run = length of the current unbroken run of stall cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run = 0; m_to = 0;
`ifdef HAZARD_PERF_EN
      m_perf = 0;
`endif
    end else begin
      if (model_stall()) begin
        if (run >= MAXW) m_to = 1;
        run = run + 1;
`ifdef HAZARD_PERF_EN
        m_perf = m_perf + 1;
`endif
      end else run = 0;
    end
  end

  always @(negedge clk) begin
    logic h1, h2;
    logic [1:0] s1, s2;
    logic [XLEN-1:0] v1, v2;
    resolve(id_rs1_sel, id_use_rs1, rgf_rs1_val, h1, s1, v1);
    resolve(id_rs2_sel, id_use_rs2, rgf_rs2_val, h2, s2, v2);
    chk("m_stall", stall, id_valid && !flush && (h1 || h2));
    chk("m_rs1_val", fwd_rs1_val, v1);
    chk("m_rs2_val", fwd_rs2_val, v2);
    chk("m_rs1_src", fwd_rs1_src, s1);
    chk("m_rs2_src", fwd_rs2_src, s2);
    chk("m_wait_cnt", wait_cnt, run > MAXW ? MAXW : run);
    chk("m_timeout", timeout_err, m_to);
`ifdef HAZARD_PERF_EN
    chk("m_perf", stall_cycles, PW'(m_perf));
`endif
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_stages();
    ex_valid = 0; ex_we = 0; ex_is_load = 0;
    mem_valid = 0; mem_we = 0; mem_is_load = 0; mem_load_done = 0;
    wb_valid = 0; wb_we = 0; flush = 0;
  endtask

  task automatic load_use_rs1(input logic [AW-1:0] r);
    clear_stages();
    id_valid = 1; id_use_rs1 = 1; id_rs1_sel = r; id_use_rs2 = 0;
    ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_rd = r; ex_val = 32'hdead;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    step(2);
    rst_n = 1;
  endtask

  initial begin
    rgf_rs1_val = 32'hAAAA0001; rgf_rs2_val = 32'hBBBB0002;
    step(2);
    chk("reset_wait_cnt", wait_cnt, 0);
    chk("reset_timeout", timeout_err, 0);
    rst_n = 1;
    step();
    // EX ALU producer forwards
    id_valid = 1; id_use_rs1 = 1; id_rs1_sel = 5;
    ex_valid = 1; ex_we = 1; ex_rd = 5; ex_val = 32'h11;
    #1;
    chk("ex_fwd_val", fwd_rs1_val, 32'h11);
    chk("ex_fwd_src", fwd_rs1_src, 1);
    chk("ex_fwd_stall", stall, 0);
    step();
    // EX ALU on rs1, pending MEM load on rs2, then load completes
    clear_stages();
    id_use_rs2 = 1; id_rs1_sel = 3; id_rs2_sel = 4;
    ex_valid = 1; ex_we = 1; ex_rd = 3; ex_val = 32'h33;
    mem_valid = 1; mem_we = 1; mem_is_load = 1; mem_rd = 4; mem_val = 32'h44;
    #1;
    chk("both_stall", stall, 1);
    chk("both_rs1_src", fwd_rs1_src, 1);
    chk("both_rs2_src", fwd_rs2_src, 0);
    chk("both_rs2_val", fwd_rs2_val, 32'hBBBB0002);
    step();
    mem_load_done = 1;
    #1;
    chk("done_stall", stall, 0);
    chk("done_rs2_val", fwd_rs2_val, 32'h44);
    chk("done_rs2_src", fwd_rs2_src, 2);
    step();
    // priority EX > MEM > WB > RGF on rs2
    clear_stages();
    id_use_rs1 = 0; id_rs2_sel = 7;
    ex_valid = 1; ex_we = 1; ex_rd = 7; ex_val = 1;
    mem_valid = 1; mem_we = 1; mem_rd = 7; mem_val = 2;
    wb_valid = 1; wb_we = 1; wb_rd = 7; wb_val = 3;
    #1;
    chk("prio_ex_val", fwd_rs2_val, 1);
    chk("prio_ex_src", fwd_rs2_src, 1);
    ex_we = 0; #1;
    chk("prio_mem_val", fwd_rs2_val, 2);
    mem_valid = 0; #1;
    chk("prio_wb_src", fwd_rs2_src, 3);
    id_use_rs2 = 0; #1;
    chk("prio_nouse_src", fwd_rs2_src, 0);
    id_use_rs2 = 1; ex_we = 1; id_rs2_sel = 0; #1;
    chk("prio_x0_val", fwd_rs2_val, 32'hBBBB0002);
    chk("prio_x0_src", fwd_rs2_src, 0);
    step();
    // long load-use hold: saturation and sticky timeout
    load_use_rs1(9);
    #1;
    chk("lu_stall", stall, 1);
    step(8);
    chk("lu_cnt8", wait_cnt, 8);
    chk("lu_no_to_yet", timeout_err, 0);
    step();
    chk("lu_cnt_sat", wait_cnt, 8);
    chk("lu_timeout", timeout_err, 1);
    ex_valid = 0; #1;
    chk("lu_clear_stall", stall, 0);
    step();
    chk("lu_cnt_clr", wait_cnt, 0);
    chk("lu_to_sticky", timeout_err, 1);
    rst_n = 0; #1;
    chk("lu_to_reset", timeout_err, 0);
    step();
    rst_n = 1;
    step();
    // flush mid-WAIT, then async reset mid-WAIT
    load_use_rs1(2);
    step(3);
    chk("fl_cnt3", wait_cnt, 3);
    flush = 1; #1;
    chk("fl_stall", stall, 0);
    step();
    chk("fl_cnt0", wait_cnt, 0);
    flush = 0;
    step(2);
    chk("rs_cnt2", wait_cnt, 2);
    #2 rst_n = 0; #1;
    chk("rs_cnt0", wait_cnt, 0);
    chk("rs_stall_in_reset", stall, 1);
    step();
    rst_n = 1;
    step();
    chk("rs_release_cnt1", wait_cnt, 1);
`ifdef HAZARD_PERF_EN
    do_reset();
    load_use_rs1(6);
    step(5);
    flush = 1;
    step();
    chk("perf_5", stall_cycles, 5);
    flush = 0;
`endif
    clear_stages();
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
